// File: rtl/unidade_controle_geogenius.sv
// Geogenius game control unit: Moore FSM sequencing LED display,
// player move capture, comparison, scoring and timeout handling.
module unidade_controle_geogenius #(
  parameter bit TIMEOUT_ATIVO = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fez_jogada,
  input  logic       jogada_igual_memoria,
  input  logic       ultima_jogada,
  input  logic       deu_timeout,
  input  logic       fim_timer_led,
  input  logic       fim_timer_resultado,
  output logic       zera_contador_jogada,
  output logic       zera_contador_score,
  output logic       zera_timer_led,
  output logic       zera_timer_resultado,
  output logic       zera_timeout,
  output logic       zeraR,
  output logic       conta_jogada,
  output logic       conta_score,
  output logic       conta_timer_led,
  output logic       conta_timer_resultado,
  output logic       conta_timeout,
  output logic       registraR,
  output logic       liga_led,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARA        = 4'h1,
    MOSTRA_LED     = 4'h2,
    INICIA_JOGADA  = 4'h3,
    ESPERA         = 4'h4,
    REGISTRA       = 4'h5,
    COMPARA        = 4'h6,
    PONTUA         = 4'h7,
    MOSTRA_ACERTO  = 4'h8,
    MOSTRA_ERRO    = 4'h9,
    MOSTRA_TIMEOUT = 4'hA,
    DECIDE         = 4'hB,
    PROXIMA        = 4'hC,
    CARREGA        = 4'hD,
    FIM            = 4'hE
  } estado_t;

  estado_t estado;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      case (estado)
        INICIAL:
          if (iniciar) estado <= PREPARA;
        PREPARA:
          estado <= MOSTRA_LED;
        MOSTRA_LED:
          if (fim_timer_led) estado <= INICIA_JOGADA;
        INICIA_JOGADA:
          estado <= ESPERA;
        // a move wins over a simultaneous timeout
        ESPERA:
          if (fez_jogada)
            estado <= REGISTRA;
          else if (deu_timeout && TIMEOUT_ATIVO)
            estado <= MOSTRA_TIMEOUT;
        REGISTRA:
          estado <= COMPARA;
        COMPARA:
          estado <= jogada_igual_memoria ? PONTUA
                                         : MOSTRA_ERRO;
        PONTUA:
          estado <= MOSTRA_ACERTO;
        MOSTRA_ACERTO, MOSTRA_ERRO, MOSTRA_TIMEOUT:
          if (fim_timer_resultado) estado <= DECIDE;
        // last flag checked before the round counter advances
        DECIDE:
          estado <= ultima_jogada ? FIM : PROXIMA;
        PROXIMA:
          estado <= CARREGA;
        CARREGA:
          estado <= MOSTRA_LED;
        FIM:
          if (iniciar) estado <= PREPARA;
        default:
          estado <= INICIAL;
      endcase
    end
  end

  always_comb begin
    zera_contador_jogada  = 1'b0;
    zera_contador_score   = 1'b0;
    zera_timer_led        = 1'b0;
    zera_timer_resultado  = 1'b0;
    zera_timeout          = 1'b0;
    zeraR                 = 1'b0;
    conta_jogada          = 1'b0;
    conta_score           = 1'b0;
    conta_timer_led       = 1'b0;
    conta_timer_resultado = 1'b0;
    conta_timeout         = 1'b0;
    registraR             = 1'b0;
    liga_led              = 1'b0;
    pronto                = 1'b0;
    acertou               = 1'b0;
    errou                 = 1'b0;
    timeout               = 1'b0;
    case (estado)
      PREPARA: begin
        zera_contador_jogada = 1'b1;
        zera_contador_score  = 1'b1;
        zera_timer_led       = 1'b1;
        zera_timer_resultado = 1'b1;
        zera_timeout         = 1'b1;
        zeraR                = 1'b1;
      end
      MOSTRA_LED: begin
        liga_led        = 1'b1;
        conta_timer_led = 1'b1;
      end
      INICIA_JOGADA: begin
        zera_timer_led = 1'b1;
        zera_timeout   = 1'b1;
        zeraR          = 1'b1;
      end
      ESPERA:   conta_timeout = 1'b1;
      REGISTRA: registraR     = 1'b1;
      PONTUA:   conta_score   = 1'b1;
      MOSTRA_ACERTO: begin
        acertou               = 1'b1;
        liga_led              = 1'b1;
        conta_timer_resultado = 1'b1;
      end
      MOSTRA_ERRO: begin
        errou                 = 1'b1;
        liga_led              = 1'b1;
        conta_timer_resultado = 1'b1;
      end
      MOSTRA_TIMEOUT: begin
        timeout               = 1'b1;
        errou                 = 1'b1;
        conta_timer_resultado = 1'b1;
      end
      DECIDE:  zera_timer_resultado = 1'b1;
      PROXIMA: conta_jogada         = 1'b1;
      CARREGA: zera_timer_led       = 1'b1;
      FIM:     pronto               = 1'b1;
      default: ;
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_geogenius.sv
// Bench for unidade_controle_geogenius: directed game scenarios plus
// random stimulus, both against a table-driven game model.
module tb_unidade_controle_geogenius;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic iniciar = 1'b0;
  logic fez_jogada = 1'b0;
  logic jogada_igual_memoria = 1'b0;
  logic ultima_jogada = 1'b0;
  logic deu_timeout = 1'b0;
  logic fim_timer_led = 1'b0;
  logic fim_timer_resultado = 1'b0;

  logic [16:0] out1, out0;
  logic [3:0]  st1, st0;

  always #5 clock = ~clock;

  // bit positions of the packed output vectors
  localparam int ZCJ = 16, ZCS = 15, ZTL = 14, ZTR = 13;
  localparam int ZTO = 12, ZR = 11, CJ = 10, CS = 9;
  localparam int CTL = 8, CTR = 7, CTO = 6, RR = 5;
  localparam int LED = 4, PRT = 3, ACE = 2, ERR = 1, TMO = 0;

  unidade_controle_geogenius dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .fez_jogada(fez_jogada),
    .jogada_igual_memoria(jogada_igual_memoria),
    .ultima_jogada(ultima_jogada),
    .deu_timeout(deu_timeout),
    .fim_timer_led(fim_timer_led),
    .fim_timer_resultado(fim_timer_resultado),
    .zera_contador_jogada(out1[ZCJ]),
    .zera_contador_score(out1[ZCS]),
    .zera_timer_led(out1[ZTL]),
    .zera_timer_resultado(out1[ZTR]),
    .zera_timeout(out1[ZTO]), .zeraR(out1[ZR]),
    .conta_jogada(out1[CJ]), .conta_score(out1[CS]),
    .conta_timer_led(out1[CTL]),
    .conta_timer_resultado(out1[CTR]),
    .conta_timeout(out1[CTO]), .registraR(out1[RR]),
    .liga_led(out1[LED]), .pronto(out1[PRT]),
    .acertou(out1[ACE]), .errou(out1[ERR]),
    .timeout(out1[TMO]), .db_estado(st1)
  );

  unidade_controle_geogenius #(.TIMEOUT_ATIVO(1'b0)) dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .fez_jogada(fez_jogada),
    .jogada_igual_memoria(jogada_igual_memoria),
    .ultima_jogada(ultima_jogada),
    .deu_timeout(deu_timeout),
    .fim_timer_led(fim_timer_led),
    .fim_timer_resultado(fim_timer_resultado),
    .zera_contador_jogada(out0[ZCJ]),
    .zera_contador_score(out0[ZCS]),
    .zera_timer_led(out0[ZTL]),
    .zera_timer_resultado(out0[ZTR]),
    .zera_timeout(out0[ZTO]), .zeraR(out0[ZR]),
    .conta_jogada(out0[CJ]), .conta_score(out0[CS]),
    .conta_timer_led(out0[CTL]),
    .conta_timer_resultado(out0[CTR]),
    .conta_timeout(out0[CTO]), .registraR(out0[RR]),
    .liga_led(out0[LED]), .pronto(out0[PRT]),
    .acertou(out0[ACE]), .errou(out0[ERR]),
    .timeout(out0[TMO]), .db_estado(st0)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  // outputs expected in each game phase, straight from the table
  logic [16:0] tbl [16];
  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    tbl[1]  = (17'(1) << ZCJ) | (17'(1) << ZCS) | (17'(1) << ZTL)
            | (17'(1) << ZTR) | (17'(1) << ZTO) | (17'(1) << ZR);
    tbl[2]  = (17'(1) << LED) | (17'(1) << CTL);
    tbl[3]  = (17'(1) << ZTL) | (17'(1) << ZTO) | (17'(1) << ZR);
    tbl[4]  = 17'(1) << CTO;
    tbl[5]  = 17'(1) << RR;
    tbl[7]  = 17'(1) << CS;
    tbl[8]  = (17'(1) << ACE) | (17'(1) << LED) | (17'(1) << CTR);
    tbl[9]  = (17'(1) << ERR) | (17'(1) << LED) | (17'(1) << CTR);
    tbl[10] = (17'(1) << TMO) | (17'(1) << ERR) | (17'(1) << CTR);
    tbl[11] = 17'(1) << ZTR;
    tbl[12] = 17'(1) << CJ;
    tbl[13] = 17'(1) << ZTL;
    tbl[14] = 17'(1) << PRT;
  end

  function automatic int nxt(input int s, input bit ta);
    case (s)
      0:  return iniciar ? 1 : 0;
      1:  return 2;
      2:  return fim_timer_led ? 3 : 2;
      3:  return 4;
      4:  return fez_jogada ? 5 :
                 (deu_timeout && ta) ? 10 : 4;
      5:  return 6;
      6:  return jogada_igual_memoria ? 7 : 9;
      7:  return 8;
      8, 9, 10: return fim_timer_resultado ? 11 : s;
      11: return ultima_jogada ? 14 : 12;
      12: return 13;
      13: return 2;
      14: return iniciar ? 1 : 14;
      default: return 0;
    endcase
  endfunction

  int m1 = 0, m0 = 0, p1 = 0, p0 = 0;
  int prev = -1, dwell = 0, decides = 0, cyc = 0;
  int n_score = 0, n_jog = 0;
  int t_reg = 0, lat = -1;
  bit wait_res = 0;
  bit k_ini = 1, k_igual = 1, k_to = 0, k_both = 0;
  int k_last = 4;

  task automatic step();
    @(negedge clock);
    cyc++;
    m1 = p1;
    m0 = p0;
    check("st1", 32'(st1), 32'(m1));
    check("out1", 32'(out1), 32'(tbl[m1]));
    check("st0", 32'(st0), 32'(m0));
    check("out0", 32'(out0), 32'(tbl[m0]));
    if (m1 == prev) dwell++;
    else dwell = 1;
    prev = m1;
    if (m1 == 1) decides = 0;
    if (m1 == 11 && dwell == 1) decides++;
    if (out1[CS]) n_score++;
    if (out1[CJ]) n_jog++;
    if (out1[RR]) begin t_reg = cyc; wait_res = 1; end
    if (wait_res && (out1[ACE] || out1[ERR])) begin
      lat = cyc - t_reg;
      wait_res = 0;
    end
  endtask

  task automatic commit();
    p1 = reset ? nxt(m1, 1'b1) : 0;
    p0 = reset ? nxt(m0, 1'b0) : 0;
  endtask

  task automatic policy();
    iniciar = k_ini && (m1 == 0 || m1 == 14);
    fim_timer_led = (m1 == 2) && dwell >= 5;
    fim_timer_resultado = (m1 >= 8 && m1 <= 10) && dwell >= 5;
    fez_jogada = (m1 == 4) && (k_both || (!k_to && dwell >= 2));
    deu_timeout = (m1 == 4) && (k_to || k_both);
    jogada_igual_memoria = k_igual;
    ultima_jogada = (decides == k_last);
  endtask

  task automatic drive_until(input int target);
    for (int i = 0; i < 300; i++) begin
      step();
      policy();
      commit();
      if (m1 == target) return;
    end
    check("budget", 32'(m1), 32'(target));
  endtask

  task automatic pulse_reset();
    step();
    reset = 1'b0;
    commit();
    step();
    reset = 1'b1;
    policy();
    commit();
  endtask

  initial begin
    // reset state
    repeat (3) begin
      step();
      commit();
    end
    check("rst_st", 32'(st1), 32'h0);
    check("rst_out", 32'(out1), 32'h0);

    // full correct game
    reset = 1'b1;
    n_score = 0;
    n_jog = 0;
    drive_until(14);
    check("score_pulses", 32'(n_score), 32'd4);
    check("jogada_pulses", 32'(n_jog), 32'd3);
    check("pronto", 32'(out1[PRT]), 32'd1);
    check("lat_acerto", 32'(lat), 32'd3);

    // restart from FIM
    drive_until(1);
    check("restart_zcs", 32'(out1[ZCS]), 32'd1);
    drive_until(2);
    check("restart_led", 32'(out1[LED]), 32'd1);

    // wrong answer
    k_igual = 0;
    n_score = 0;
    drive_until(9);
    check("lat_erro", 32'(lat), 32'd2);
    check("errou", 32'(out1[ERR]), 32'd1);
    check("acertou", 32'(out1[ACE]), 32'd0);
    drive_until(11);
    check("no_score", 32'(n_score), 32'd0);

    // timeout, honoured only with TIMEOUT_ATIVO=1
    k_igual = 1;
    k_to = 1;
    drive_until(10);
    check("to_st1", 32'(st1), 32'hA);
    check("to_flag", 32'(out1[TMO]), 32'd1);
    check("to_st0", 32'(st0), 32'h4);
    pulse_reset();

    // simultaneous move and timeout
    k_both = 1;
    drive_until(5);
    check("both_st", 32'(st1), 32'h5);
    check("both_rr", 32'(out1[RR]), 32'd1);
    k_both = 0;
    k_to = 0;

    // asynchronous reset in MOSTRA_ACERTO
    drive_until(8);
    #2 reset = 1'b0;
    #1;
    check("async_st", 32'(st1), 32'h0);
    check("async_out", 32'(out1), 32'h0);
    check("async_st0", 32'(st0), 32'h0);
    m1 = 0;
    m0 = 0;
    commit();
    step();
    reset = 1'b1;
    drive_until(1);
    check("after_rst_zera", 32'(out1[16:11]), 32'h3F);

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      step();
      reset = ($urandom_range(0, 59) != 0);
      iniciar = ($urandom_range(0, 3) == 0);
      fez_jogada = ($urandom_range(0, 3) == 0);
      deu_timeout = ($urandom_range(0, 3) == 0);
      jogada_igual_memoria = $urandom_range(0, 1) == 1;
      ultima_jogada = ($urandom_range(0, 2) == 0);
      fim_timer_led = $urandom_range(0, 1) == 1;
      fim_timer_resultado = $urandom_range(0, 1) == 1;
      commit();
    end
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/unidade_controle_geogenius.md
UNIDADE_CONTROLE_GEOGENIUS -- requirements
Module: unidade_controle_geogenius

Interface
REQ-001 The module SHALL have one parameter: TIMEOUT_ATIVO, default 1, meaning 1 = deu_timeout is honoured and 0 = deu_timeout is ignored.
REQ-002 clock  input  1  single system clock; all state changes occur on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low; 0 forces state INICIAL immediately.
REQ-004 iniciar  input  1  level request to start a game.
REQ-005 fez_jogada, jogada_igual_memoria, ultima_jogada, deu_timeout, fim_timer_led, fim_timer_resultado  input  1 each  datapath status flags.
REQ-006 zera_contador_jogada, zera_contador_score, zera_timer_led, zera_timer_resultado, zera_timeout, zeraR  output  1 each  datapath clears.
REQ-007 conta_jogada, conta_score, conta_timer_led, conta_timer_resultado, conta_timeout, registraR, liga_led  output  1 each  datapath enables.
REQ-008 pronto, acertou, errou, timeout  output  1 each  game status; db_estado  output  4  current state code.

Function
REQ-009 The block SHALL be a Moore FSM: a registered state, with every output decoded combinationally from the state only.
REQ-010 Outputs not listed as asserted for a state SHALL be 0 in that state.
REQ-011 States, codes, asserted outputs and transitions SHALL be:
- INICIAL 0x0: no outputs; iniciar=1 -> PREPARA.
- PREPARA 0x1: all six zera_* outputs; unconditional -> MOSTRA_LED.
- MOSTRA_LED 0x2: liga_led, conta_timer_led; fim_timer_led=1 -> INICIA_JOGADA.
- INICIA_JOGADA 0x3: zera_timer_led, zera_timeout, zeraR; -> ESPERA.
- ESPERA 0x4: conta_timeout; fez_jogada=1 -> REGISTRA; else deu_timeout=1 with TIMEOUT_ATIVO=1 -> MOSTRA_TIMEOUT.
- REGISTRA 0x5: registraR; -> COMPARA.
- COMPARA 0x6: no outputs; jogada_igual_memoria=1 -> PONTUA; else -> MOSTRA_ERRO.
- PONTUA 0x7: conta_score for exactly one cycle; -> MOSTRA_ACERTO.
- MOSTRA_ACERTO 0x8: acertou, liga_led, conta_timer_resultado; fim_timer_resultado=1 -> DECIDE.
- MOSTRA_ERRO 0x9: errou, liga_led, conta_timer_resultado; fim_timer_resultado=1 -> DECIDE.
- MOSTRA_TIMEOUT 0xA: timeout, errou, conta_timer_resultado; fim_timer_resultado=1 -> DECIDE.
- DECIDE 0xB: zera_timer_resultado; ultima_jogada=1 -> FIM; else -> PROXIMA.
- PROXIMA 0xC: conta_jogada for exactly one cycle; -> CARREGA.
- CARREGA 0xD: zera_timer_led; one cycle for the synchronous ROM to present the new flag; -> MOSTRA_LED.
- FIM 0xE: pronto; iniciar=1 -> PREPARA; else hold.
REQ-012 Unused code 0xF SHALL go to INICIAL on the next edge.
REQ-013 Simultaneous fez_jogada and deu_timeout in ESPERA SHALL give priority to fez_jogada.
REQ-014 fez_jogada in any state other than ESPERA SHALL be ignored.
REQ-015 conta_score SHALL be asserted at most once per jogada.
REQ-016 conta_jogada SHALL be asserted at most once per jogada.
REQ-017 Latency from fez_jogada (sampled in ESPERA) to acertou or errou SHALL be 3 cycles on the acerto path and 2 cycles on the erro path.
REQ-018 iniciar held high during play SHALL have no effect outside INICIAL and FIM.
REQ-019 ultima_jogada SHALL be evaluated only in DECIDE, before conta_jogada is pulsed, so the last flag is never skipped and the counter never wraps within a game.
REQ-020 db_estado SHALL equal the current state code in every cycle.

Reset
REQ-021 reset=0 SHALL asynchronously force state INICIAL in any state, including mid-jogada.
REQ-022 While reset=0 and in INICIAL, all outputs SHALL be 0 and db_estado SHALL be 0x0.
REQ-023 After reset is released, the datapath SHALL be cleared only via PREPARA; a game is never resumed.

Verification
REQ-024 Full correct game: reset, iniciar pulse, each timer flag after 5 cycles, fez_jogada with jogada_igual_memoria=1 each round, ultima_jogada on the 4th DECIDE -> 4 conta_score pulses, 3 conta_jogada pulses, FIM with pronto=1.
REQ-025 Wrong answer: jogada_igual_memoria=0 in COMPARA -> errou=1 and acertou=0 until fim_timer_resultado; no conta_score pulse.
REQ-026 Timeout: deu_timeout=1 in ESPERA with TIMEOUT_ATIVO=1 -> MOSTRA_TIMEOUT (db_estado=0xA) with timeout=1; with TIMEOUT_ATIVO=0 -> remains in ESPERA.
REQ-027 Simultaneous fez_jogada and deu_timeout in ESPERA -> next state REGISTRA (0x5), registraR=1.
REQ-028 reset=0 asserted mid-cycle while in MOSTRA_ACERTO -> db_estado=0x0 before the next edge and all outputs 0; a later iniciar -> PREPARA with all zera_* outputs=1.
REQ-029 Restart from FIM: iniciar=1 -> PREPARA, then MOSTRA_LED with liga_led=1 and score cleared.
